otter_mem_responder: RTL and testbench
======================================

Name: otter_mem_responder

Overview:
- Memory-side responder for the OTTER multicycle core.
- Services the control unit's strobes:
  - port 1: instruction fetch via MEM_RDEN1.
  - port 2: data load/store via MEM_RDEN2 and MEM_WE2.
- Fixed one-cycle registered read latency, which is the latency the fetch/execute/writeback sequencing is built around.
- Decodes a memory-mapped IO region and does byte/halfword/word lane steering with sign extension.

Parameters:
- DEPTH_WORDS, 16384, number of 32-bit words in the array (power of 2).
- IO_BASE, 32'h1100_0000, addresses >= IO_BASE on port 2 are IO, not memory.
- TEXT_TOP, 32'h0000_1000, first byte address above the protected text region (used only with the optional feature).

Ports:
- clk  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- MEM_RDEN1  in  1  instruction read strobe.
- MEM_ADDR1  in  32  instruction byte address (PC).
- MEM_DOUT1  out  32  instruction word, registered.
- MEM_RDEN2  in  1  data read strobe.
- MEM_WE2  in  1  data write strobe.
- MEM_ADDR2  in  32  data byte address.
- MEM_DIN2  in  32  store data, right-justified.
- MEM_SIZE  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- MEM_SIGN  in  1  1 = zero-extend (unsigned load), 0 = sign-extend.
- MEM_DOUT2  out  32  load data, extended, registered.
- IO_IN  in  32  IO read data.
- IO_OUT  out  32  IO write data, registered.
- IO_WR  out  1  IO write pulse.
- ERR_MISALIGN  out  1  misaligned/illegal access pulse.
- ERR_PROT  out  1  text-protect violation pulse (tied 0 when feature is off).

Behaviour:
- Reset:
  - RST high at an edge clears MEM_DOUT1, MEM_DOUT2, IO_OUT, IO_WR, ERR_MISALIGN and ERR_PROT to 0.
  - All writes are suppressed while RST is high.
  - Array contents are not cleared.
- Indexing:
  - word index = ADDR[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored for array access, so addresses alias (wrap) modulo DEPTH_WORDS*4.
- Port 1:
  - On an edge with MEM_RDEN1=1: MEM_DOUT1 <= mem[index(ADDR1)].
  - MEM_ADDR1[1:0] is ignored.
  - MEM_DOUT1 holds its value when MEM_RDEN1=0.
  - Port 1 never accesses IO.
- Alignment check on port 2:
  - Legal: byte at any address; half with ADDR2[0]=0; word with ADDR2[1:0]=00.
  - Illegal: anything else, including SIZE=11.
- Illegal port-2 access (RDEN2 or WE2 high):
  - Write is suppressed.
  - A read loads MEM_DOUT2 <= 0.
  - ERR_MISALIGN is high for exactly the one cycle following the edge.
- Port 2 read, legal, memory region:
  - On the edge: select lane(s) by ADDR2[1:0] and SIZE, extend per MEM_SIGN, then register into MEM_DOUT2.
  - Data is valid the cycle after the strobe and holds until the next RDEN2 edge.
- Port 2 read, legal, IO region: MEM_DOUT2 <= IO_IN sampled at the edge, with no lane steering.
- Port 2 write, legal, memory region:
  - Only the addressed byte lanes are written.
  - Byte: DIN2[7:0] goes to lane ADDR2[1:0].
  - Half: DIN2[15:0] goes to lanes {ADDR2[1],0}+1:0.
  - Word: all lanes.
- Port 2 write, legal, IO region:
  - IO_OUT <= MEM_DIN2.
  - IO_WR is high for exactly the one cycle after the edge.
  - IO_OUT holds until the next IO write.
  - The array is not written.
- Simultaneous events:
  - RDEN2 and WE2 at the same address on the same edge: read returns pre-write data (read-before-write), and the write commits.
  - Port 1 read of a word being written by port 2 on the same edge returns old data.
- Latency:
  - No wait states; a new access can be issued every cycle on each port.
  - Error flags are never sticky.

Optional Feature:
- Macro: OTTER_MEM_TEXT_PROTECT_EN.
- Defined:
  - Any legal memory-region port-2 write with ADDR2 < TEXT_TOP is suppressed.
  - ERR_PROT is high for the one cycle after the edge.
  - Reads are unaffected.
  - A misaligned write below TEXT_TOP raises only ERR_MISALIGN.
- Undefined: all legal writes commit, and ERR_PROT is a constant 0.

Test Plan:
- Reset then fetch: preload mem[4]=32'hDEAD_BEEF; RST=1 for 2 cycles, then RDEN1=1 with ADDR1=0x10 → MEM_DOUT1=0xDEADBEEF exactly one cycle later; all outputs 0 during reset.
- Byte/half sign extension: mem[8]=32'h80FF_7F01.
  - LB at 0x21 → 0xFFFFFF7F? No, lane 1 = 0x7F, so 0x0000007F.
  - LB at 0x22 → 0xFFFFFFFF.
  - LBU at 0x22 → 0x000000FF.
  - LH at 0x22 → 0xFFFF80FF.
  - LHU at 0x22 → 0x000080FF.
- Lane-masked store: mem[8]=0; SB 0xAB at 0x23, then SH 0x1234 at 0x20 → word read at 0x20 = 0xAB001234.
- Misaligned: LW at 0x22 → MEM_DOUT2=0 and ERR_MISALIGN pulses 1 cycle. SH 0x5555 at 0x21 → memory unchanged, ERR_MISALIGN pulses.
- IO path:
  - SW 0x0000_00A5 at 0x1100_0000 → IO_OUT=0xA5 with a one-cycle IO_WR pulse, and the array is not written.
  - IO_IN=0x1234 and LW at 0x1100_0004 → MEM_DOUT2=0x1234.
- Read-before-write: mem[2]=0x11111111; RDEN2 and WE2 on the same edge at 0x8 with DIN2=0x22222222 → MEM_DOUT2=0x11111111, next read returns 0x22222222. With OTTER_MEM_TEXT_PROTECT_EN and TEXT_TOP=0x1000, the same write at 0x8 leaves 0x11111111 and pulses ERR_PROT.

Source files
------------

// File: rtl/otter_mem_responder.sv
// ---------------------------------------------------------------------------
// otter_mem_responder
//
// Memory-side responder for the OTTER multicycle core. It serves two ports
// from one word array. Both ports have a fixed one-cycle registered read
// latency.
//   Port 1 : instruction fetch (MEM_RDEN1 / MEM_ADDR1 -> MEM_DOUT1).
//            This port never touches IO.
//   Port 2 : data load/store (MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2,
//            MEM_SIZE, MEM_SIGN -> MEM_DOUT2).
//            Addresses >= IO_BASE go to the IO port instead of the array.
//            Byte and halfword accesses are steered to the correct lanes,
//            and loads are sign- or zero-extended.
//
// Ports
//   clk, RST      clock; synchronous active-high reset (array is not cleared)
//   MEM_RDEN1     instruction read strobe
//   MEM_ADDR1     instruction byte address; bits [1:0] are ignored
//   MEM_DOUT1     registered instruction word; holds while MEM_RDEN1 = 0
//   MEM_RDEN2     data read strobe
//   MEM_WE2       data write strobe
//   MEM_ADDR2     data byte address
//   MEM_DIN2      right-justified store data
//   MEM_SIZE      00 byte, 01 half, 10 word, 11 illegal
//   MEM_SIGN      1 = zero-extend, 0 = sign-extend
//   MEM_DOUT2     registered, extended load data; holds between reads
//   IO_IN         IO read data
//   IO_OUT        registered IO write data
//   IO_WR         one-cycle IO write pulse
//   ERR_MISALIGN  one-cycle pulse for a misaligned or illegal-size access
//   ERR_PROT      one-cycle pulse for a write into the text region
//
// Optional feature
//   Define OTTER_MEM_TEXT_PROTECT_EN to enable text protection. With it
//   defined, a legal memory-region write with MEM_ADDR2 < TEXT_TOP is
//   dropped and ERR_PROT pulses. Without it, ERR_PROT is tied to 0.
// ---------------------------------------------------------------------------
module otter_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter logic [31:0] IO_BASE     = 32'h1100_0000,
    parameter logic [31:0] TEXT_TOP    = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        MEM_RDEN1,
    input  logic [31:0] MEM_ADDR1,
    output logic [31:0] MEM_DOUT1,
    input  logic        MEM_RDEN2,
    input  logic        MEM_WE2,
    input  logic [31:0] MEM_ADDR2,
    input  logic [31:0] MEM_DIN2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_SIGN,
    output logic [31:0] MEM_DOUT2,
    input  logic [31:0] IO_IN,
    output logic [31:0] IO_OUT,
    output logic        IO_WR,
    output logic        ERR_MISALIGN,
    output logic        ERR_PROT
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // NOTE: the array has no reset; its contents survive RST and are only
    // changed by writes. This keeps it mappable onto block RAM.
    logic [31:0] mem [DEPTH_WORDS];

    // Upper address bits are dropped, so array addresses wrap.
    logic [AW-1:0] idx1, idx2;
    assign idx1 = MEM_ADDR1[AW+1:2];
    assign idx2 = MEM_ADDR2[AW+1:2];

    // ---------------- port-2 decode ----------------
    logic        is_io2;
    logic        legal2;
    logic        prot_hit;
    logic        mem_we;
    logic        io_we;
    logic [3:0]  be;
    logic [31:0] wdata;

    always_comb begin
        is_io2 = (MEM_ADDR2 >= IO_BASE);
        case (MEM_SIZE)
            SZ_BYTE: legal2 = 1'b1;
            SZ_HALF: legal2 = ~MEM_ADDR2[0];
            SZ_WORD: legal2 = (MEM_ADDR2[1:0] == 2'b00);
            default: legal2 = 1'b0;
        endcase
    end

`ifdef OTTER_MEM_TEXT_PROTECT_EN
    assign prot_hit = MEM_WE2 && legal2 && !is_io2 && (MEM_ADDR2 < TEXT_TOP);
`else
    assign prot_hit = 1'b0;
`endif

    assign mem_we = !RST && MEM_WE2 && legal2 && !is_io2 && !prot_hit;
    assign io_we  = !RST && MEM_WE2 && legal2 && is_io2;

    // Store data is replicated across lanes, so only the enables depend on
    // the address offset.
    always_comb begin
        case (MEM_SIZE)
            SZ_BYTE: begin
                be    = 4'b0001 << MEM_ADDR2[1:0];
                wdata = {4{MEM_DIN2[7:0]}};
            end
            SZ_HALF: begin
                be    = MEM_ADDR2[1] ? 4'b1100 : 4'b0011;
                wdata = {2{MEM_DIN2[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = MEM_DIN2;
            end
        endcase
    end

    // NOTE: the array write is non-blocking. Any read in the same cycle
    // therefore sees the old word, which gives read-before-write on both
    // ports without any extra bypass logic.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx2][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- load lane steering ----------------
    logic [31:0] rd_word2;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        rd_word2 = mem[idx2];
        ld_byte  = rd_word2[{MEM_ADDR2[1:0], 3'b000} +: 8];
        ld_half  = MEM_ADDR2[1] ? rd_word2[31:16] : rd_word2[15:0];
        case (MEM_SIZE)
            SZ_BYTE: ld_ext = {{24{~MEM_SIGN & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{~MEM_SIGN & ld_half[15]}}, ld_half};
            default: ld_ext = rd_word2;
        endcase
    end

    // ---------------- output registers ----------------
    logic [31:0] dout1_q, dout1_d;
    logic [31:0] dout2_q, dout2_d;
    logic [31:0] io_out_q, io_out_d;
    logic        io_wr_q, io_wr_d;
    logic        err_misalign_q, err_misalign_d;
    logic        err_prot_d;

    // NOTE: each next-state value defaults to its hold value before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        dout1_d        = dout1_q;
        dout2_d        = dout2_q;
        io_out_d       = io_out_q;
        io_wr_d        = io_we;
        err_misalign_d = (MEM_RDEN2 || MEM_WE2) && !legal2;
        err_prot_d     = prot_hit;

        if (MEM_RDEN1) dout1_d = mem[idx1];

        if (MEM_RDEN2) begin
            if (!legal2)     dout2_d = 32'h0;
            else if (is_io2) dout2_d = IO_IN;
            else             dout2_d = ld_ext;
        end

        if (io_we) io_out_d = MEM_DIN2;

        if (RST) begin
            dout1_d        = 32'h0;
            dout2_d        = 32'h0;
            io_out_d       = 32'h0;
            io_wr_d        = 1'b0;
            err_misalign_d = 1'b0;
            err_prot_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        dout1_q        <= dout1_d;
        dout2_q        <= dout2_d;
        io_out_q       <= io_out_d;
        io_wr_q        <= io_wr_d;
        err_misalign_q <= err_misalign_d;
    end

    assign MEM_DOUT1    = dout1_q;
    assign MEM_DOUT2    = dout2_q;
    assign IO_OUT       = io_out_q;
    assign IO_WR        = io_wr_q;
    assign ERR_MISALIGN = err_misalign_q;

`ifdef OTTER_MEM_TEXT_PROTECT_EN
    logic err_prot_q;
    always_ff @(posedge clk) begin
        err_prot_q <= err_prot_d;
    end
    assign ERR_PROT = err_prot_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, MEM_ADDR1[31:AW+2], MEM_ADDR1[1:0]};
`else
    assign ERR_PROT = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, MEM_ADDR1[31:AW+2], MEM_ADDR1[1:0], err_prot_d, TEXT_TOP};
`endif

endmodule

// File: tb/tb_otter_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_otter_mem_responder
//
// Drives directed and randomized traffic into otter_mem_responder. A byte-
// addressed reference memory tracks what every output must be on every
// cycle. Directed steps also pin exact literal values.
// ---------------------------------------------------------------------------
module tb_otter_mem_responder;

    localparam int unsigned DW       = 16384;
    localparam int unsigned MEMB     = DW * 4;
    localparam logic [31:0] IO_BASE  = 32'h1100_0000;
    localparam logic [31:0] TEXT_TOP = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rden1 = 1'b0;
    logic [31:0] a1 = 32'h0;
    logic        rden2 = 1'b0;
    logic        we2 = 1'b0;
    logic [31:0] a2 = 32'h0;
    logic [31:0] din = 32'h0;
    logic [1:0]  size = 2'b00;
    logic        sign = 1'b0;
    logic [31:0] ioin = 32'h0;
    logic [31:0] dout1, dout2, io_out;
    logic        io_wr, err_mis, err_prot;

    int checks = 0;
    int errors = 0;

    otter_mem_responder #(
        .DEPTH_WORDS(DW),
        .IO_BASE    (IO_BASE),
        .TEXT_TOP   (TEXT_TOP)
    ) dut (
        .clk         (clk),
        .RST         (rst),
        .MEM_RDEN1   (rden1),
        .MEM_ADDR1   (a1),
        .MEM_DOUT1   (dout1),
        .MEM_RDEN2   (rden2),
        .MEM_WE2     (we2),
        .MEM_ADDR2   (a2),
        .MEM_DIN2    (din),
        .MEM_SIZE    (size),
        .MEM_SIGN    (sign),
        .MEM_DOUT2   (dout2),
        .IO_IN       (ioin),
        .IO_OUT      (io_out),
        .IO_WR       (io_wr),
        .ERR_MISALIGN(err_mis),
        .ERR_PROT    (err_prot)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mb [MEMB];
    bit         kb [MEMB];   // byte has been written with a known value

    function automatic bit is_legal(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b11) return 1'b0;
        return (a % (32'd1 << s)) == 32'd0;
    endfunction

    function automatic logic [31:0] bidx(input logic [31:0] a, input int i);
        return (a + 32'(i)) % 32'(MEMB);
    endfunction

    logic [31:0] e_d1, e_d2, e_io;
    bit          k_d1 = 1'b0, k_d2 = 1'b0;
    bit          e_iowr, e_mis, e_prot;
    bit          seen_rst = 1'b0;

    always @(posedge clk) begin : monitor
        bit          io, lg, pr;
        int          n;
        logic [31:0] v, base;
        if (rst) begin
            e_d1 = 0; k_d1 = 1; e_d2 = 0; k_d2 = 1;
            e_io = 0; e_iowr = 0; e_mis = 0; e_prot = 0;
            seen_rst = 1;
        end else begin
            io = (a2 >= IO_BASE);
            lg = is_legal(a2, size);
            n  = 1 << size;
            e_mis = (rden2 || we2) && !lg;
            pr = 1'b0;
`ifdef OTTER_MEM_TEXT_PROTECT_EN
            pr = we2 && lg && !io && (a2 < TEXT_TOP);
`endif
            e_prot = pr;
            if (rden1) begin
                base = a1 & ~32'd3;
                e_d1 = 0; k_d1 = 1;
                for (int i = 0; i < 4; i++) begin
                    e_d1 |= 32'(mb[bidx(base, i)]) << (8 * i);
                    k_d1 &= kb[bidx(base, i)];
                end
            end
            if (rden2) begin
                if (!lg) begin
                    e_d2 = 0; k_d2 = 1;
                end else if (io) begin
                    e_d2 = ioin; k_d2 = 1;
                end else begin
                    v = 0; k_d2 = 1;
                    for (int i = 0; i < n; i++) begin
                        v |= 32'(mb[bidx(a2, i)]) << (8 * i);
                        k_d2 &= kb[bidx(a2, i)];
                    end
                    if (!sign && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
                    e_d2 = v;
                end
            end
            e_iowr = we2 && lg && io;
            if (e_iowr) e_io = din;
            // Reads above used the pre-write contents.
            if (we2 && lg && !io && !pr) begin
                for (int i = 0; i < n; i++) begin
                    mb[bidx(a2, i)] = din[8*i +: 8];
                    kb[bidx(a2, i)] = 1'b1;
                end
            end
        end
        #1;
        if (seen_rst) begin
            if (k_d1) check("mon_dout1", dout1, e_d1);
            if (k_d2) check("mon_dout2", dout2, e_d2);
            check("mon_io_out", io_out, e_io);
            check("mon_io_wr", {31'b0, io_wr}, {31'b0, e_iowr});
            check("mon_err_misalign", {31'b0, err_mis}, {31'b0, e_mis});
            check("mon_err_prot", {31'b0, err_prot}, {31'b0, e_prot});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit rd1, input logic [31:0] ad1,
                         input bit rd2, input bit w2, input logic [31:0] ad2,
                         input logic [31:0] d, input logic [1:0] sz, input bit sg,
                         input logic [31:0] ii);
        @(negedge clk);
        rst = r; rden1 = rd1; a1 = ad1; rden2 = rd2; we2 = w2; a2 = ad2;
        din = d; size = sz; sign = sg; ioin = ii;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0);
    endtask

    task automatic st(input logic [31:0] ad, input logic [31:0] d, input logic [1:0] sz);
        drive(0, 0, 32'h0, 0, 1, ad, d, sz, 0, 32'h0);
    endtask

    task automatic ld(input logic [31:0] ad, input logic [1:0] sz, input bit sg);
        drive(0, 0, 32'h0, 1, 0, ad, 32'h0, sz, sg, 32'h0);
    endtask

    initial begin
        // Reset and fetch. Stores go through alias +0x10000 so they land
        // above the text region but in the same array words.
        drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        check("rst_dout1", dout1, 32'h0);
        check("rst_dout2", dout2, 32'h0);
        check("rst_io_out", io_out, 32'h0);
        check("rst_flags", {29'b0, io_wr, err_mis, err_prot}, 32'h0);
        st(32'h0001_0010, 32'hDEAD_BEEF, 2'b10);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        drive(1, 0, 32'h0, 0, 1, 32'h0001_0010, 32'h0BAD_0BAD, 2'b10, 0, 32'h0);
        check("rst2_dout2", dout2, 32'h0);
        drive(0, 1, 32'h0000_0010, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        check("fetch_0x10", dout1, 32'hDEAD_BEEF);
        idle();
        check("fetch_hold", dout1, 32'hDEAD_BEEF);

        // Sign/zero extension.
        st(32'h0001_0020, 32'h80FF_7F01, 2'b10);
        ld(32'h21, 2'b00, 0); check("lb_0x21", dout2, 32'h0000_007F);
        ld(32'h22, 2'b00, 0); check("lb_0x22", dout2, 32'hFFFF_FFFF);
        ld(32'h22, 2'b00, 1); check("lbu_0x22", dout2, 32'h0000_00FF);
        ld(32'h22, 2'b01, 0); check("lh_0x22", dout2, 32'hFFFF_80FF);
        ld(32'h22, 2'b01, 1); check("lhu_0x22", dout2, 32'h0000_80FF);
        idle();
        check("ld_hold", dout2, 32'h0000_80FF);

        // Lane-masked stores.
        st(32'h0001_0020, 32'h0, 2'b10);
        st(32'h0001_0023, 32'hFFFF_FFAB, 2'b00);
        st(32'h0001_0020, 32'hFFFF_1234, 2'b01);
        ld(32'h20, 2'b10, 0); check("lane_store", dout2, 32'hAB00_1234);

        // Misaligned accesses.
        ld(32'h22, 2'b10, 0);
        check("mis_lw_data", dout2, 32'h0);
        check("mis_lw_flag", {31'b0, err_mis}, 32'h1);
        idle();
        check("mis_flag_clear", {31'b0, err_mis}, 32'h0);
        st(32'h0001_0021, 32'h5555, 2'b01);
        check("mis_sh_flag", {31'b0, err_mis}, 32'h1);
        ld(32'h20, 2'b10, 0); check("mis_sh_nowrite", dout2, 32'hAB00_1234);
        ld(32'h20, 2'b11, 0); check("size11_flag", {31'b0, err_mis}, 32'h1);

        // IO path.
        st(32'h0001_0000, 32'h0C0F_FEE0, 2'b10);
        st(IO_BASE, 32'h0000_00A5, 2'b10);
        check("io_out", io_out, 32'h0000_00A5);
        check("io_wr_pulse", {31'b0, io_wr}, 32'h1);
        idle();
        check("io_wr_clear", {31'b0, io_wr}, 32'h0);
        check("io_out_hold", io_out, 32'h0000_00A5);
        ld(32'h0, 2'b10, 0); check("io_no_array_write", dout2, 32'h0C0F_FEE0);
        drive(0, 0, 32'h0, 1, 0, IO_BASE + 32'h4, 32'h0, 2'b10, 0, 32'h0000_1234);
        check("io_read", dout2, 32'h0000_1234);

        // Read-before-write on port 2.
        st(32'h0001_0008, 32'h1111_1111, 2'b10);
        drive(0, 0, 32'h0, 1, 1, 32'h8, 32'h2222_2222, 2'b10, 0, 32'h0);
        check("rbw_old_data", dout2, 32'h1111_1111);
`ifdef OTTER_MEM_TEXT_PROTECT_EN
        check("rbw_prot", {31'b0, err_prot}, 32'h1);
        ld(32'h8, 2'b10, 0); check("rbw_after", dout2, 32'h1111_1111);
`else
        check("rbw_prot", {31'b0, err_prot}, 32'h0);
        ld(32'h8, 2'b10, 0); check("rbw_after", dout2, 32'h2222_2222);
`endif

        // Port 1 reading a word that port 2 writes on the same edge.
        st(32'h0001_0040, 32'hAAAA_5555, 2'b10);
        drive(0, 1, 32'h40, 0, 1, 32'h0001_0040, 32'h1234_5678, 2'b10, 0, 32'h0);
        check("p1_old_data", dout1, 32'hAAAA_5555);
        drive(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0);
        check("p1_new_data", dout1, 32'h1234_5678);

        // Fill the random windows so the model knows their contents.
        for (int w = 0; w < 256; w++) begin
            st(32'h2000 + 32'(4 * w), $urandom, 2'b10);
            st(32'(4 * w), $urandom, 2'b10);
        end

        // Randomized traffic, checked every cycle by the monitor.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ad2, ad1;
            logic [31:0] off;
            off = 32'($urandom_range(0, 1023));
            case ($urandom_range(0, 3))
                0: ad2 = 32'h2000 + off;
                1: ad2 = 32'h1_2000 + off;
                2: ad2 = off;
                default: ad2 = IO_BASE + off;
            endcase
            ad1 = ($urandom_range(0, 1) == 1) ? 32'h2000 + off : off;
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 1) == 1, ad1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ad2,
                  $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  $urandom);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
